// File: rtl/mem_check_pkg.sv
// Shared types for the memory-write checker: FSM states and failure codes.
package mem_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/mem_check_table.sv
// Expectation table: DEPTH (address, data) pairs, synchronous write port,
// combinational read of the entry currently being waited for.
module mem_check_table #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IW    = 2,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IW-1:0]    wr_idx_i,
    input  logic [WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [CW-1:0]    rd_idx_i,
    output logic [WIDTH-1:0] rd_addr_o,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [2*WIDTH-1:0] entries [DEPTH];
    logic [2*WIDTH-1:0] rd_entry;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [2*WIDTH-1:0] entry_q;

            // Out-of-range indices match no entry and are dropped.
            always_ff @(posedge clk) begin
                if (we_i && (32'(wr_idx_i) == gi)) begin
                    entry_q <= {wr_addr_i, wr_data_i};
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        rd_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(rd_idx_i) == i) begin
                rd_entry = entries[i];
            end
        end
    end

    assign rd_addr_o = rd_entry[2*WIDTH-1:WIDTH];
    assign rd_data_o = rd_entry[WIDTH-1:0];

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write bus against an ordered list of expected
// stores, tolerating one scratch address, with a run-time watchdog.
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int  WIDTH   = 32,
    parameter int  DEPTH   = 4,
    parameter int  TIMEOUT = 1000,
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [CW-1:0]    num_exp,
    input  logic             ign_en,
    input  logic [WIDTH-1:0] ign_addr,
    input  logic             start,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data,
    output logic [CW-1:0]    match_count,
    output logic [15:0]      ign_count
);

    state_t           state_q, state_d;
    logic [CW-1:0]    match_q, match_d;
    logic [CW-1:0]    num_q, num_d;
    logic             ign_en_q, ign_en_d;
    logic [WIDTH-1:0] ign_addr_q, ign_addr_d;
    logic [15:0]      ign_cnt_q, ign_cnt_d;
    logic [TW-1:0]    cyc_q, cyc_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [WIDTH-1:0] faddr_q, faddr_d;
    logic [WIDTH-1:0] fdata_q, fdata_d;

    logic [WIDTH-1:0] exp_addr, exp_data;
    logic [CW-1:0]    num_lim;
    logic             is_ign, is_hit, is_last, is_timeout;

    mem_check_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW),
        .CW    (CW)
    ) u_table (
        .clk       (clk),
        .we_i      (cfg_we && (state_q != RUN)),
        .wr_idx_i  (cfg_idx),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_idx_i  (match_q),
        .rd_addr_o (exp_addr),
        .rd_data_o (exp_data)
    );

    assign num_lim    = (32'(num_exp) > DEPTH) ? CW'(DEPTH) : num_exp;
    assign is_ign     = ign_en_q && (dataadr == ign_addr_q);
    assign is_hit     = (dataadr == exp_addr) && (writedata == exp_data);
    assign is_last    = (CW'(match_q + CW'(1)) == num_q);
    assign is_timeout = (32'(cyc_q) == TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            match_q    <= '0;
            num_q      <= '0;
            ign_en_q   <= 1'b0;
            ign_addr_q <= '0;
            ign_cnt_q  <= '0;
            cyc_q      <= '0;
            fcode_q    <= FC_NONE;
            faddr_q    <= '0;
            fdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            num_q      <= num_d;
            ign_en_q   <= ign_en_d;
            ign_addr_q <= ign_addr_d;
            ign_cnt_q  <= ign_cnt_d;
            cyc_q      <= cyc_d;
            fcode_q    <= fcode_d;
            faddr_q    <= faddr_d;
            fdata_q    <= fdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        num_d      = num_q;
        ign_en_d   = ign_en_q;
        ign_addr_d = ign_addr_q;
        ign_cnt_d  = ign_cnt_q;
        cyc_d      = cyc_q;
        fcode_d    = fcode_q;
        faddr_d    = faddr_q;
        fdata_d    = fdata_q;

        unique case (state_q)
            RUN: begin
                cyc_d = cyc_q + TW'(1);
                if (memwrite) begin
                    if (is_ign) begin
                        if (ign_cnt_q != 16'hFFFF) begin
                            ign_cnt_d = ign_cnt_q + 16'd1;
                        end
                    end else if (is_hit) begin
                        match_d = match_q + CW'(1);
                        if (is_last) begin
                            state_d = PASS;
                        end
                    end else begin
                        state_d = FAIL;
                        fcode_d = FC_MISMATCH;
                        faddr_d = dataadr;
                        fdata_d = writedata;
                    end
                end
                // A decisive write on the final cycle takes precedence over the watchdog.
                if ((state_d == RUN) && is_timeout) begin
                    state_d = FAIL;
                    fcode_d = FC_TIMEOUT;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
            default: begin
                if (start) begin
                    num_d      = num_lim;
                    ign_en_d   = ign_en;
                    ign_addr_d = ign_addr;
                    match_d    = '0;
                    ign_cnt_d  = '0;
                    cyc_d      = '0;
                    fcode_d    = FC_NONE;
                    faddr_d    = '0;
                    fdata_d    = '0;
                    state_d    = (num_lim == '0) ? PASS : RUN;
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        pass = (state_q == PASS);
        fail = (state_q == FAIL);
    end

    assign fail_code   = fcode_q;
    assign fail_addr   = faddr_q;
    assign fail_data   = fdata_q;
    assign match_count = match_q;
    assign ign_count   = ign_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized runs
// checked cycle by cycle against a queue-based reference model.
module tb_mem_write_checker;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic [2:0]  num_exp = '0;
    logic        ign_en = 1'b0;
    logic [31:0] ign_addr = '0;
    logic        start = 1'b0;
    logic        busy, pass, fail;
    logic [1:0]  fail_code;
    logic [31:0] fail_addr, fail_data;
    logic [2:0]  match_count;
    logic [15:0] ign_count;

    int n_cmp = 0;
    int n_err = 0;

    mem_write_checker #(
        .WIDTH   (32),
        .DEPTH   (4),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .num_exp     (num_exp),
        .ign_en      (ign_en),
        .ign_addr    (ign_addr),
        .start       (start),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .fail_code   (fail_code),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .match_count (match_count),
        .ign_count   (ign_count)
    );

    always #5 clk = ~clk;

    // Reference model: the run is a queue of still-pending stores.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } store_t;

    store_t      tbl [4];
    store_t      pend [$];
    int          m_phase;   // 0 idle, 1 running, 2 passed, 3 failed
    int          m_match, m_ign, m_elapsed, m_code;
    logic [31:0] m_faddr, m_fdata, m_ign_addr;
    bit          m_ign_en;

    task automatic model_edge();
        if (reset) begin
            m_phase = 0; m_match = 0; m_ign = 0; m_elapsed = 0; m_code = 0;
            m_faddr = '0; m_fdata = '0;
            pend.delete();
        end else if (m_phase != 1) begin
            if (cfg_we) tbl[cfg_idx] = '{cfg_addr, cfg_data};
            if (start) begin
                int n;
                n = (int'(num_exp) > 4) ? 4 : int'(num_exp);
                pend.delete();
                for (int i = 0; i < n; i++) pend.push_back(tbl[i]);
                m_match = 0; m_ign = 0; m_elapsed = 0; m_code = 0;
                m_faddr = '0; m_fdata = '0;
                m_ign_en = ign_en; m_ign_addr = ign_addr;
                m_phase = (n == 0) ? 2 : 1;
            end
        end else begin
            bit ended;
            ended = 1'b0;
            if (memwrite) begin
                if (m_ign_en && dataadr == m_ign_addr) begin
                    if (m_ign < 65535) m_ign++;
                end else if (dataadr == pend[0].a && writedata == pend[0].d) begin
                    void'(pend.pop_front());
                    m_match++;
                    if (pend.size() == 0) begin m_phase = 2; ended = 1'b1; end
                end else begin
                    m_phase = 3; m_code = 1; m_faddr = dataadr; m_fdata = writedata;
                    ended = 1'b1;
                end
            end
            if (!ended && m_elapsed == TMO - 1) begin
                m_phase = 3; m_code = 2; m_faddr = '0; m_fdata = '0;
            end
            m_elapsed++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] n, input logic ie, input logic [31:0] ia);
        start = 1'b1; num_exp = n; ign_en = ie; ign_addr = ia;
        step();
        start = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        step();
        memwrite = 1'b0;
        $display("wr adr=%0d data=%0d -> busy=%0b pass=%0b fail=%0b code=%0d match=%0d ign=%0d",
                 a, d, busy, pass, fail, fail_code, match_count, ign_count);
    endtask

    task automatic load_four();
        cfg_write(0, 32'd0, 32'd1);
        cfg_write(1, 32'd4, 32'd2);
        cfg_write(2, 32'd8, 32'd3);
        cfg_write(3, 32'd12, 32'd4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({busy, pass, fail} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got=%b want=000", {busy, pass, fail});
        end
        n_cmp++;
        if ({fail_code, fail_addr, fail_data, match_count, ign_count} !== '0) begin
            n_err++; $display("FAIL reset_outputs code=%0d addr=%0d data=%0d match=%0d ign=%0d want all 0",
                              fail_code, fail_addr, fail_data, match_count, ign_count);
        end
        $display("reset checked");
    endtask

    task automatic test_ignore_then_match();
        cfg_write(0, 32'd84, 32'd7);
        do_start(3'd1, 1'b1, 32'd80);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start got=%b want=1", busy); end
        bus_write(32'd80, 32'd3);
        bus_write(32'd80, 32'd5);
        n_cmp++;
        if ({busy, pass} !== 2'b10) begin
            n_err++; $display("FAIL still_running got busy,pass=%b want=10", {busy, pass});
        end
        bus_write(32'd84, 32'd7);
        n_cmp++;
        if ({pass, fail} !== 2'b10) begin n_err++; $display("FAIL ign_pass got=%b want=10", {pass, fail}); end
        n_cmp++;
        if (ign_count !== 16'd2) begin n_err++; $display("FAIL ign_count got=%0d want=2", ign_count); end
        n_cmp++;
        if (match_count !== 3'd1) begin n_err++; $display("FAIL ign_match got=%0d want=1", match_count); end
    endtask

    task automatic test_mismatch();
        do_start(3'd1, 1'b1, 32'd80);
        bus_write(32'd88, 32'd7);
        n_cmp++;
        if ({pass, fail, fail_code} !== 4'b0101) begin
            n_err++; $display("FAIL mismatch_flags got pass=%b fail=%b code=%0d want 0 1 1", pass, fail, fail_code);
        end
        n_cmp++;
        if ({fail_addr, fail_data} !== {32'd88, 32'd7}) begin
            n_err++; $display("FAIL mismatch_capture got=%0d/%0d want=88/7", fail_addr, fail_data);
        end
        bus_write(32'd84, 32'd7);
        n_cmp++;
        if ({pass, fail} !== 2'b01) begin n_err++; $display("FAIL fail_sticky got=%b want=01", {pass, fail}); end
    endtask

    task automatic test_timeout();
        int k;
        do_start(3'd1, 1'b0, 32'd0);
        k = 0;
        while (fail !== 1'b1 && k < 2 * TMO) begin
            step();
            k++;
        end
        n_cmp++;
        if (k != TMO) begin n_err++; $display("FAIL timeout_cycles got=%0d want=%0d", k, TMO); end
        n_cmp++;
        if (fail_code !== 2'd2) begin n_err++; $display("FAIL timeout_code got=%0d want=2", fail_code); end
        n_cmp++;
        if ({fail_addr, fail_data} !== 64'd0) begin
            n_err++; $display("FAIL timeout_capture got=%0d/%0d want=0/0", fail_addr, fail_data);
        end
        $display("timeout after %0d cycles", k);
    endtask

    task automatic test_in_order();
        load_four();
        do_start(3'd4, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) bus_write(32'(4 * i), 32'(i + 1));
        n_cmp++;
        if ({pass, match_count} !== {1'b1, 3'd4}) begin
            n_err++; $display("FAIL in_order got pass=%b match=%0d want 1 4", pass, match_count);
        end
        do_start(3'd4, 1'b0, 32'd0);
        bus_write(32'd4, 32'd2);
        n_cmp++;
        if ({fail, fail_code, fail_addr, match_count} !== {1'b1, 2'd1, 32'd4, 3'd0}) begin
            n_err++; $display("FAIL out_of_order got fail=%b code=%0d addr=%0d match=%0d want 1 1 4 0",
                              fail, fail_code, fail_addr, match_count);
        end
        // num_exp above DEPTH behaves as DEPTH
        do_start(3'd7, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) bus_write(32'(4 * i), 32'(i + 1));
        n_cmp++;
        if ({pass, match_count} !== {1'b1, 3'd4}) begin
            n_err++; $display("FAIL clamp got pass=%b match=%0d want 1 4", pass, match_count);
        end
    endtask

    task automatic test_final_on_timeout();
        cfg_write(0, 32'd64, 32'd9);
        do_start(3'd1, 1'b0, 32'd0);
        for (int i = 0; i < TMO - 1; i++) step();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL edge_busy got=%b want=1", busy); end
        bus_write(32'd64, 32'd9);
        n_cmp++;
        if ({pass, fail, fail_code} !== 4'b1000) begin
            n_err++; $display("FAIL edge_pass got pass=%b fail=%b code=%0d want 1 0 0", pass, fail, fail_code);
        end
        do_start(3'd0, 1'b0, 32'd0);
        n_cmp++;
        if ({busy, pass, fail} !== 3'b010) begin
            n_err++; $display("FAIL num_zero got=%b want=010", {busy, pass, fail});
        end
    endtask

    task automatic test_reset_mid_run();
        load_four();
        do_start(3'd4, 1'b1, 32'd100);
        bus_write(32'd100, 32'd0);
        bus_write(32'd0, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({busy, pass, fail, fail_code, fail_addr, fail_data, match_count, ign_count} !== '0) begin
            n_err++; $display("FAIL mid_reset got busy=%b pass=%b fail=%b match=%0d ign=%0d want all 0",
                              busy, pass, fail, match_count, ign_count);
        end
        load_four();
        do_start(3'd4, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) bus_write(32'(4 * i), 32'(i + 1));
        n_cmp++;
        if ({pass, match_count} !== {1'b1, 3'd4}) begin
            n_err++; $display("FAIL after_reset got pass=%b match=%0d want 1 4", pass, match_count);
        end
    endtask

    task automatic test_random();
        logic [87:0] got_v, exp_v;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 4; i++)
                cfg_write(i, 32'($urandom_range(0, 7) * 4), 32'($urandom_range(0, 3)));
            do_start(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4));
            for (int c = 0; c < TMO + 4; c++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                memwrite = 1'b0;
                if (sel <= 4 && m_phase == 1) begin
                    memwrite = 1'b1; dataadr = pend[0].a; writedata = pend[0].d;
                end else if (sel <= 6) begin
                    memwrite = 1'b1; dataadr = m_ign_addr; writedata = 32'($urandom_range(0, 3));
                end else if (sel == 7) begin
                    memwrite = 1'b1; dataadr = 32'($urandom_range(0, 7) * 4);
                    writedata = 32'($urandom_range(0, 3));
                end
                // Restart and reconfiguration attempts while running must be ignored.
                if (m_phase == 1 && $urandom_range(0, 9) == 0) begin
                    start = 1'b1; num_exp = 3'($urandom_range(0, 7));
                    cfg_we = 1'b1; cfg_idx = 2'($urandom_range(0, 3)); cfg_data = $urandom;
                end
                step();
                memwrite = 1'b0; start = 1'b0; cfg_we = 1'b0;
                got_v = {busy, pass, fail, fail_code, fail_addr, fail_data, match_count, ign_count};
                exp_v = {m_phase == 1, m_phase == 2, m_phase == 3, 2'(m_code), m_faddr, m_fdata,
                         3'(m_match), 16'(m_ign)};
                n_cmp++;
                if (got_v !== exp_v) begin
                    n_err++; $display("FAIL random run=%0d cyc=%0d got=%h want=%h", r, c, got_v, exp_v);
                end
            end
            $display("random run %0d -> pass=%0b fail=%0b code=%0d match=%0d ign=%0d",
                     r, pass, fail, fail_code, match_count, ign_count);
        end
    endtask

    initial begin
        test_reset();
        test_ignore_then_match();
        test_mismatch();
        test_timeout();
        test_in_order();
        test_final_on_timeout();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised monitor for the CPU data-memory write bus that replaces ad-hoc pass/fail logic in the top-level bench. It watches `memwrite`/`dataadr`/`writedata` from `top` and checks the stream against a programmable ordered list of expected (address, data) stores. Stores to one configurable scratch address are tolerated. A watchdog bounds run time. The block sits beside `top` in the bench or on an FPGA self-test wrapper and reports sticky pass/fail plus diagnostics.

## Interface
- `WIDTH`, 32, address/data width
- `DEPTH`, 4, maximum number of expected stores
- `TIMEOUT`, 1000, cycles allowed in RUN before timeout failure (≥1)
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-high
- `memwrite` in 1, data-memory write strobe
- `dataadr` in WIDTH, write address
- `writedata` in WIDTH, write data
- `cfg_we` in 1, write one expectation entry
- `cfg_idx` in $clog2(DEPTH), entry index
- `cfg_addr`, `cfg_data` in WIDTH, expected address/data for entry
- `num_exp` in $clog2(DEPTH+1), number of valid entries, sampled on `start`
- `ign_en` in 1, enable scratch-address tolerance; `ign_addr` in WIDTH, scratch address (sampled on `start`)
- `start` in 1, one-cycle pulse begins a run
- `busy` out 1, high in RUN
- `pass`, `fail` out 1, sticky result flags
- `fail_code` out 2, 0 none, 1 MISMATCH, 2 TIMEOUT
- `fail_addr`, `fail_data` out WIDTH, offending write (zero on timeout)
- `match_count` out $clog2(DEPTH+1), expected stores matched so far
- `ign_count` out 16, tolerated scratch writes (saturates at 0xFFFF)

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE; all outputs and counters 0; expectation table contents undefined.
- `cfg_we` is honoured in IDLE, PASS and FAIL; ignored in RUN. `cfg_idx` ≥ DEPTH is ignored.
- `start` in IDLE/PASS/FAIL: latch `num_exp`, `ign_en`, `ign_addr`; clear counters, flags, `fail_*`; → RUN. If `num_exp` = 0 → PASS instead. `start` in RUN is ignored. A `num_exp` value above DEPTH is clamped to DEPTH.
- RUN, per cycle with `memwrite`=1, checked in priority order:
  1. The cycle is tolerated if `ign_en` and `dataadr` == `ign_addr`. `ign_count`++ and the state is unchanged.
  2. If `dataadr`/`writedata` equal entry[`match_count`], `match_count`++. When this write is the last expected store, → PASS.
  3. Otherwise → FAIL with code MISMATCH, capturing `dataadr`/`writedata`.
- An expected entry whose address equals `ign_addr` is shadowed by rule 1. This is legal.
- RUN cycle counter: if it reaches TIMEOUT-1 with no PASS/FAIL transition that cycle → FAIL with code TIMEOUT.
- PASS/FAIL are sticky until `start` or `reset`. `memwrite` there is ignored.

## Timing
- Single cycle: the decision uses the bus values at edge N. `pass`/`fail`/`fail_*`/counters are updated at edge N (visible after it). No pipelining.
- `busy` is high the cycle after `start` is sampled.
- Simultaneous final matching write and timeout expiry → PASS. Simultaneous mismatch and timeout → MISMATCH.
- Simultaneous `cfg_we` and `start` in IDLE: the entry is written, and the run uses the new value only from the next cycle. Software must not rely on it for entry 0.
- `reset` mid-RUN → IDLE next edge and all outputs 0. The table is not guaranteed to be preserved.
- `pass` and `fail` are never both 1.

## Structure
- Package `mem_check_pkg`: state enum (IDLE/RUN/PASS/FAIL) and `fail_code` constants (FC_NONE/FC_MISMATCH/FC_TIMEOUT).
- One sub-module, `mem_check_table`: DEPTH×(2·WIDTH) register file with synchronous write port and combinational read at `match_count`.
- The top module holds the FSM, counters and capture registers.

## Test plan
- Load entry0 = (84, 7), `num_exp`=1, `ign_en`=1, `ign_addr`=80. Stimulus: writes (80, 3), (80, 5), (84, 7). Expected: `pass`=1 one edge after the last write, `ign_count`=2, `match_count`=1.
- Same config, write (88, 7). Expected: `fail`=1, `fail_code`=1, `fail_addr`=88, `fail_data`=7.
- TIMEOUT=20, no writes. Expected: `fail`=1, `fail_code`=2 exactly 20 cycles after `busy` rises.
- DEPTH=4, entries (0, 1), (4, 2), (8, 3), (12, 4). Stimulus: in-order writes. Expected: `pass`. Rerun with (4, 2) sent first. Expected: MISMATCH, `fail_addr`=4, `match_count`=0.
- Final matching write on the timeout cycle. Expected: PASS. Separately, `num_exp`=0. Expected: PASS the cycle after `start`.
- Assert `reset` mid-RUN after 1 match. Expected: all outputs 0, IDLE. A new `start` with reloaded entries runs normally.
